// File: rtl/washer_cycle_ctrl_if.sv
// rtl/washer_cycle_ctrl_if.sv - panel/sensor inputs and valve/motor outputs of the washer sequencer
interface washer_cycle_ctrl_if #(
    parameter int RINSE_W = 2
) ();
    logic               start;
    logic               door_closed;
    logic               water_full;
    logic               drained;
    logic               detergent_ok;
    logic               pause;
    logic [RINSE_W-1:0] rinse_cnt;
    logic               door_lock;
    logic               fill_valve;
    logic               drain_valve;
    logic               motor_on;
    logic               motor_fast;
    logic               done;
    logic               fault;
    logic [1:0]         fault_code;
    logic [3:0]         state_o;

    modport slave (
        input  start, door_closed, water_full, drained, detergent_ok, pause, rinse_cnt,
        output door_lock, fill_valve, drain_valve, motor_on, motor_fast, done, fault,
               fault_code, state_o
    );

    modport master (
        output start, door_closed, water_full, drained, detergent_ok, pause, rinse_cnt,
        input  door_lock, fill_valve, drain_valve, motor_on, motor_fast, done, fault,
               fault_code, state_o
    );
endinterface

// File: rtl/washer_cycle_ctrl.sv
// rtl/washer_cycle_ctrl.sv - washer sequencer; define WM_FAULT_TIMEOUT_EN for the FILL/DRAIN watchdog
module washer_cycle_ctrl #(
    parameter int TMR_W       = 16,
    parameter int WASH_TICKS  = 200,
    parameter int RINSE_TICKS = 100,
    parameter int SPIN_TICKS  = 150,
    parameter int RINSE_W     = 2,
    parameter int FILL_LIMIT  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    washer_cycle_ctrl_if.slave   bus
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FILL      = 4'd1;
    localparam logic [3:0] S_DETERGENT = 4'd2;
    localparam logic [3:0] S_WASH      = 4'd3;
    localparam logic [3:0] S_DRAIN     = 4'd4;
    localparam logic [3:0] S_SPIN      = 4'd5;
    localparam logic [3:0] S_DONE      = 4'd6;
    localparam logic [3:0] S_PAUSE     = 4'd7;
    localparam logic [3:0] S_FAULT     = 4'd8;

    // Timers are loaded with TICKS-1 so that exiting at zero gives exactly TICKS cycles
    localparam logic [TMR_W-1:0] WASH_LOAD  = TMR_W'(WASH_TICKS - 1);
    localparam logic [TMR_W-1:0] RINSE_LOAD = TMR_W'(RINSE_TICKS - 1);
    localparam logic [TMR_W-1:0] SPIN_LOAD  = TMR_W'(SPIN_TICKS - 1);

    logic [3:0]         state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [RINSE_W-1:0] rinse_left, rinse_nxt;
    logic               main_flag, main_nxt;
    logic               saved_spin, saved_nxt;
    logic [1:0]         fault_code_r, fc_nxt;
    logic               door_trip;

`ifdef WM_FAULT_TIMEOUT_EN
    localparam int WD_W = $clog2(FILL_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            in_wd_state;

    assign in_wd_state = (state == S_FILL) || (state == S_DRAIN);
    assign wd_expired  = (wd_cnt == WD_W'(FILL_LIMIT - 1));

    // Watchdog restarts on each entry to FILL/DRAIN and counts while waiting there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if (in_wd_state) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    logic [31:0] unused_fill_limit;
    assign unused_fill_limit = 32'(FILL_LIMIT);
`endif

    // Door opening while the drum may hold water or spin overrides every other transition
    assign door_trip = !bus.door_closed &&
                       (state != S_IDLE) && (state != S_DONE) && (state != S_FAULT);

    // Next-state, timer and cycle bookkeeping
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        rinse_nxt = rinse_left;
        main_nxt  = main_flag;
        saved_nxt = saved_spin;
        fc_nxt    = fault_code_r;
        if (door_trip) begin
            state_nxt = S_FAULT;
            fc_nxt    = 2'b01;
            timer_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && bus.door_closed) begin
                        state_nxt = S_FILL;
                        rinse_nxt = bus.rinse_cnt;
                        main_nxt  = 1'b1;
                    end
                end
                S_FILL: begin
                    if (bus.water_full) begin
                        if (main_flag) begin
                            state_nxt = S_DETERGENT;
                        end else begin
                            state_nxt = S_WASH;
                            timer_nxt = RINSE_LOAD;
                        end
                    end
`ifdef WM_FAULT_TIMEOUT_EN
                    else if (wd_expired) begin
                        state_nxt = S_FAULT;
                        fc_nxt    = 2'b10;
                    end
`endif
                end
                S_DETERGENT: begin
                    if (bus.detergent_ok) begin
                        state_nxt = S_WASH;
                        timer_nxt = main_flag ? WASH_LOAD : RINSE_LOAD;
                    end
                end
                S_WASH: begin
                    if (bus.pause) begin
                        state_nxt = S_PAUSE;
                        saved_nxt = 1'b0;
                    end else if (timer == '0) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.drained) begin
                        if (rinse_left != '0) begin
                            state_nxt = S_FILL;
                            rinse_nxt = rinse_left - RINSE_W'(1);
                            main_nxt  = 1'b0;
                        end else begin
                            state_nxt = S_SPIN;
                            timer_nxt = SPIN_LOAD;
                        end
                    end
`ifdef WM_FAULT_TIMEOUT_EN
                    else if (wd_expired) begin
                        state_nxt = S_FAULT;
                        fc_nxt    = 2'b11;
                    end
`endif
                end
                S_SPIN: begin
                    if (bus.pause) begin
                        state_nxt = S_PAUSE;
                        saved_nxt = 1'b1;
                    end else if (timer == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                S_PAUSE: begin
                    if (!bus.pause) begin
                        state_nxt = saved_spin ? S_SPIN : S_WASH;
                    end
                end
                S_FAULT: begin
                    if (bus.start && bus.drained) begin
                        state_nxt = S_IDLE;
                        fc_nxt    = 2'b00;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // State and bookkeeping registers; asynchronous reset aborts any cycle in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            rinse_left   <= '0;
            main_flag    <= 1'b0;
            saved_spin   <= 1'b0;
            fault_code_r <= 2'b00;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            rinse_left   <= rinse_nxt;
            main_flag    <= main_nxt;
            saved_spin   <= saved_nxt;
            fault_code_r <= fc_nxt;
        end
    end

    // Moore actuator decode; door stays latched in FAULT until the drum is empty
    always_comb begin
        bus.door_lock   = 1'b0;
        bus.fill_valve  = 1'b0;
        bus.drain_valve = 1'b0;
        bus.motor_on    = 1'b0;
        bus.motor_fast  = 1'b0;
        bus.done        = 1'b0;
        bus.fault       = 1'b0;
        case (state)
            S_FILL: begin
                bus.door_lock  = 1'b1;
                bus.fill_valve = 1'b1;
            end
            S_DETERGENT: begin
                bus.door_lock = 1'b1;
            end
            S_WASH: begin
                bus.door_lock = 1'b1;
                bus.motor_on  = 1'b1;
            end
            S_DRAIN: begin
                bus.door_lock   = 1'b1;
                bus.drain_valve = 1'b1;
            end
            S_SPIN: begin
                bus.door_lock   = 1'b1;
                bus.drain_valve = 1'b1;
                bus.motor_on    = 1'b1;
                bus.motor_fast  = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            S_PAUSE: begin
                bus.door_lock   = 1'b1;
                bus.drain_valve = saved_spin;
            end
            S_FAULT: begin
                bus.door_lock   = !bus.drained;
                bus.drain_valve = 1'b1;
                bus.fault       = 1'b1;
            end
            default: begin
                bus.door_lock = 1'b0;
            end
        endcase
    end

    assign bus.fault_code = fault_code_r;
    assign bus.state_o    = state;
endmodule
